// File: rtl/multi_client_axis_pkg.sv
// Shared widths, defaults and FSM encoding for the multi-channel AXIS client.
package multi_client_axis_pkg;

  localparam int DATAW_DEF      = 16;
  localparam int AXIS_DESTW     = 4;
  localparam int AXIS_IDW       = 4;
  localparam int AXIS_STRBW     = 8;
  localparam int AXIS_KEEPW     = 8;
  localparam int AXIS_USERW     = 4;
  localparam int AXIS_MAX_DATAW = 64;

  localparam logic [AXIS_USERW-1:0] SRC_ADDR_DEF  = 4'h1;
  localparam logic [AXIS_DESTW-1:0] DEST_ADDR_DEF = 4'h0;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_SEND = 1'b1
  } mc_state_e;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_client_axis_fifo.sv
// Per-channel beat FIFO: synchronous, show-ahead head, occupancy counter.
module multi_client_axis_fifo
  import multi_client_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_wr;
  logic                  do_rd;

  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous read and write leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/multi_client_axis.sv
// Multi-channel client front end: per-channel FIFOs merged onto one AXIS master
// with packet-granular round-robin arbitration.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  MC_IDLE | no packet owns the output; pick next non-empty channel
//  MC_SEND | grant locked to one channel until its tlast beat is accepted
module multi_client_axis
  import multi_client_axis_pkg::*;
#(
  parameter int                             NUM_CH     = 2,
  parameter int                             FIFO_DEPTH = 8,
  parameter int                             DATAW      = DATAW_DEF,
  parameter logic [NUM_CH*AXIS_DESTW-1:0]   DEST_ADDRS = {NUM_CH{DEST_ADDR_DEF}},
  parameter logic [AXIS_USERW-1:0]          SRC_ADDR   = SRC_ADDR_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*DATAW-1:0]     client_tdata,
  input  logic [NUM_CH-1:0]           client_tlast,
  input  logic [NUM_CH-1:0]           client_valid,
  output logic [NUM_CH-1:0]           client_ready,
  input  logic                        axis_client_interface_tready,
  output logic                        axis_client_interface_tvalid,
  output logic                        axis_client_interface_tlast,
  output logic [AXIS_DESTW-1:0]       axis_client_interface_tdest,
  output logic [AXIS_IDW-1:0]         axis_client_interface_tid,
  output logic [AXIS_STRBW-1:0]       axis_client_interface_tstrb,
  output logic [AXIS_KEEPW-1:0]       axis_client_interface_tkeep,
  output logic [AXIS_USERW-1:0]       axis_client_interface_tuser,
  output logic [AXIS_MAX_DATAW-1:0]   axis_client_interface_tdata
);

  localparam int GW = clog2_min1(NUM_CH);

  mc_state_e         state, state_nxt;
  logic [GW-1:0]     grant, grant_nxt;
  logic [GW-1:0]     rr_ptr, rr_ptr_nxt;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;
  logic [DATAW:0]    head [NUM_CH];
  logic [DATAW-1:0]  head_data;
  logic              head_last;
  logic              out_valid;
  logic              hs;

  // First requesting channel at or after start, wrapping at NUM_CH.
  function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] start,
                                            input logic [NUM_CH-1:0] req);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(start) + k) % NUM_CH;
      if (!found && req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_en[i] = client_valid[i] & ~full[i];
    assign rd_en[i] = hs && (int'(grant) == i);

    multi_client_axis_fifo #(
      .DATA_WIDTH (DATAW + 1),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[i]),
      .wr_data ({client_tlast[i], client_tdata[i*DATAW +: DATAW]}),
      .rd_en   (rd_en[i]),
      .rd_data (head[i]),
      .empty   (empty[i]),
      .full    (full[i])
    );
  end

  assign {head_last, head_data} = head[grant];
  assign hs                     = out_valid & axis_client_interface_tready;
  assign client_ready           = ~full;

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MC_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Arbitration: pick in IDLE, hold grant in SEND until the tlast beat is accepted.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    out_valid  = 1'b0;
    case (state)
      MC_IDLE: begin
        if (~empty != '0) begin
          grant_nxt = rr_pick(rr_ptr, ~empty);
          state_nxt = MC_SEND;
        end
      end
      MC_SEND: begin
        out_valid = ~empty[grant];
        if (out_valid && axis_client_interface_tready && head_last) begin
          state_nxt  = MC_IDLE;
          rr_ptr_nxt = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
        end
      end
      default: state_nxt = MC_IDLE;
    endcase
  end

  // Output beat; data and last are zeroed while no beat is offered.
  always_comb begin
    axis_client_interface_tdata                = '0;
    axis_client_interface_tdata[DATAW-1:0]     = out_valid ? head_data : '0;
    axis_client_interface_tid                  = '0;
    axis_client_interface_tid[GW-1:0]          = grant;
    axis_client_interface_tlast                = out_valid & head_last;
    axis_client_interface_tdest                = DEST_ADDRS[int'(grant)*AXIS_DESTW +: AXIS_DESTW];
  end

  assign axis_client_interface_tvalid = out_valid;
  assign axis_client_interface_tstrb  = '0;
  assign axis_client_interface_tkeep  = '0;
  assign axis_client_interface_tuser  = SRC_ADDR;

endmodule
